// File: rtl/ysyx_22041461_div_pkg.sv
// Shared definitions for the iterative divider.
//   - div_state_e   : control FSM states (IDLE / BUSY / DONE)
//   - DEF_XLEN/WLEN : default datapath and word-operation widths
//   - QUO_ALL_ONES  : quotient returned for a zero divisor. It is sized for the
//                     widest supported datapath (MAX_XLEN) and sliced down to
//                     XLEN by users.
package ysyx_22041461_div_pkg;

    localparam int DEF_XLEN = 64;
    localparam int DEF_WLEN = 32;
    localparam int MAX_XLEN = 128;

    localparam logic [MAX_XLEN-1:0] QUO_ALL_ONES = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/ysyx_22041461_iter_div_if.sv
// Request/response bundle for ysyx_22041461_iter_div.
//   master : the requester (drives operands, controls, flush, out_ready)
//   slave  : the divider   (drives in_ready, out_valid, div_out)
interface ysyx_22041461_iter_div_if #(
    parameter int XLEN = ysyx_22041461_div_pkg::DEF_XLEN
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            div_signed;
    logic            div_rem;
    logic            div_word;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] div_out;

    modport master (
        output in_valid, src1, src2, div_signed, div_rem, div_word, flush, out_ready,
        input  in_ready, out_valid, div_out
    );

    modport slave (
        input  in_valid, src1, src2, div_signed, div_rem, div_word, flush, out_ready,
        output in_ready, out_valid, div_out
    );
endinterface

// File: rtl/ysyx_22041461_div_pre.sv
// Combinational operand conditioning for the divider.
//   src1/src2   : raw dividend / divisor
//   div_signed  : operands are two's complement
//   div_word    : only the low WLEN bits are meaningful
//   op1         : dividend after word truncation/extension (used by special cases)
//   mag1/mag2   : unsigned magnitudes of dividend / divisor
//   neg_quo     : quotient must be negated at the end
//   neg_rem     : remainder must be negated at the end
//   div_zero    : divisor is zero
//   sgn_ovf     : most-negative / -1 signed overflow
module ysyx_22041461_div_pre
    import ysyx_22041461_div_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int WLEN = DEF_WLEN
) (
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            div_signed,
    input  logic            div_word,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] mag1,
    output logic [XLEN-1:0] mag2,
    output logic            neg_quo,
    output logic            neg_rem,
    output logic            div_zero,
    output logic            sgn_ovf
);

    localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}};

    logic [XLEN-1:0] op2;
    logic            s1;
    logic            s2;

    // Low WLEN bits pass through; upper bits are either the raw input or, in
    // word mode, the sign (signed) or zero (unsigned) extension of bit WLEN-1.
    for (genvar gi = 0; gi < XLEN; gi++) begin : g_ext
        if (gi < WLEN) begin : g_low
            assign op1[gi] = src1[gi];
            assign op2[gi] = src2[gi];
        end else begin : g_high
            assign op1[gi] = div_word ? (div_signed & src1[WLEN-1]) : src1[gi];
            assign op2[gi] = div_word ? (div_signed & src2[WLEN-1]) : src2[gi];
        end
    end

    always_comb begin
        s1 = div_signed & op1[XLEN-1];
        s2 = div_signed & op2[XLEN-1];
        // The most negative value maps onto itself, which read as unsigned is
        // exactly its magnitude, so no extra bit is needed.
        mag1     = s1 ? -op1 : op1;
        mag2     = s2 ? -op2 : op2;
        neg_quo  = s1 ^ s2;
        neg_rem  = s1;
        div_zero = (op2 == '0);
        sgn_ovf  = div_signed && (op2 == '1) && (op1 == (div_word ? MIN_W : MIN_X));
    end

endmodule

// File: rtl/ysyx_22041461_iter_div.sv
// Iterative radix-2 restoring divider.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : request handshake (accepted only in IDLE)
//   src1, src2          : dividend, divisor
//   div_signed/rem/word : signed operands / return remainder / low-WLEN mode
//   flush               : abandon the current operation, back to IDLE
//   out_valid/out_ready : result handshake (held in DONE)
//   DIV_out             : result, holds its last value outside DONE
// Normal operations spend W cycles in BUSY (one quotient bit each); a zero
// divisor or signed overflow is resolved at accept and goes straight to DONE.
module ysyx_22041461_iter_div
    import ysyx_22041461_div_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int WLEN = DEF_WLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            div_signed,
    input  logic            div_rem,
    input  logic            div_word,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] DIV_out
);

    localparam int CW = $clog2(XLEN + 1);

    div_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dsr_q, dsr_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;
    logic            selr_q, selr_d;
    logic            word_q, word_d;
    logic [XLEN-1:0] div_out_q, div_out_d;

    logic [XLEN-1:0] op1, mag1, mag2;
    logic            neg_quo, neg_rem, div_zero, sgn_ovf;

    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] step_rem, step_quo;
    logic [XLEN-1:0] fin_quo, fin_rem;
    logic [XLEN-1:0] spec_raw;

    ysyx_22041461_div_pre #(
        .XLEN(XLEN),
        .WLEN(WLEN)
    ) u_pre (
        .src1      (src1),
        .src2      (src2),
        .div_signed(div_signed),
        .div_word  (div_word),
        .op1       (op1),
        .mag1      (mag1),
        .mag2      (mag2),
        .neg_quo   (neg_quo),
        .neg_rem   (neg_rem),
        .div_zero  (div_zero),
        .sgn_ovf   (sgn_ovf)
    );

    // Word results are always sign-extended from bit WLEN-1, even unsigned ones.
    function automatic logic [XLEN-1:0] fmt_res(input logic [XLEN-1:0] v, input logic w);
        return w ? {{(XLEN-WLEN){v[WLEN-1]}}, v[WLEN-1:0]} : v;
    endfunction

    always_comb begin
        // One restoring step: shift the next dividend bit (MSB of quo) into the
        // partial remainder and subtract when it does not borrow.
        rem_shift = {rem_q, quo_q[XLEN-1]};
        diff      = rem_shift - {1'b0, dsr_q};
        step_rem  = diff[XLEN] ? rem_shift[XLEN-1:0] : diff[XLEN-1:0];
        step_quo  = {quo_q[XLEN-2:0], ~diff[XLEN]};
        fin_quo   = negq_q ? -step_quo : step_quo;
        fin_rem   = negr_q ? -step_rem : step_rem;

        if (div_zero) begin
            spec_raw = div_rem ? op1 : QUO_ALL_ONES[XLEN-1:0];
        end else begin
            spec_raw = div_rem ? '0 : op1;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dsr_d     = dsr_q;
        negq_d    = negq_q;
        negr_d    = negr_q;
        selr_d    = selr_q;
        word_d    = word_q;
        div_out_d = div_out_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    negq_d = neg_quo;
                    negr_d = neg_rem;
                    selr_d = div_rem;
                    word_d = div_word;
                    if (div_zero || sgn_ovf) begin
                        div_out_d = fmt_res(spec_raw, div_word);
                        state_d   = DONE;
                    end else begin
                        cnt_d   = div_word ? CW'(WLEN) : CW'(XLEN);
                        // Align the word dividend's MSB with quo's MSB so the
                        // same shifter serves both widths.
                        quo_d   = div_word ? (mag1 << (XLEN - WLEN)) : mag1;
                        rem_d   = '0;
                        dsr_d   = mag2;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                quo_d = step_quo;
                rem_d = step_rem;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    div_out_d = fmt_res(selr_q ? fin_rem : fin_quo, word_q);
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush wins over every handshake and never delivers a result.
        if (flush) begin
            state_d   = IDLE;
            cnt_d     = '0;
            div_out_d = div_out_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dsr_q     <= '0;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
            selr_q    <= 1'b0;
            word_q    <= 1'b0;
            div_out_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dsr_q     <= dsr_d;
            negq_q    <= negq_d;
            negr_q    <= negr_d;
            selr_q    <= selr_d;
            word_q    <= word_d;
            div_out_q <= div_out_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign DIV_out   = div_out_q;

endmodule
